// File: rtl/quad_decoder_modn_if.sv
// Bundle of the encoder phase inputs, control strobes and position outputs of quad_decoder_modn.
// The master side (controller/encoder) drives the inputs; the slave side (the decoder) drives the results.
interface quad_decoder_modn_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             clear;
  logic             err_clr;
  logic             qa;
  logic             qb;
  logic [WIDTH-1:0] position;
  logic             dir;
  logic             step;
  logic             wrap;
  logic             err;

  modport master (
    output enable, clear, err_clr, qa, qb,
    input  position, dir, step, wrap, err
  );

  modport slave (
    input  enable, clear, err_clr, qa, qb,
    output position, dir, step, wrap, err
  );
endinterface

// File: rtl/quad_decoder_modn.sv
// Quadrature A/B decoder with a mod-N position counter, wrap pulse and sticky illegal-transition flag.
// Phase lines are synchronised, and each legal Gray-code step moves the position by exactly one.
module quad_decoder_modn #(
  parameter int N           = 10,
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  quad_decoder_modn_if.slave  bus
);

  typedef enum logic [1:0] {
    MOVE_NONE    = 2'b00,
    MOVE_UP      = 2'b01,
    MOVE_DOWN    = 2'b10,
    MOVE_ILLEGAL = 2'b11
  } move_t;

  localparam logic [WIDTH-1:0] POS_MAX  = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] POS_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1);

  // Classify the move from the previous to the current {a,b} sample.
  function automatic move_t decode_move(input logic [1:0] p, input logic [1:0] c);
    move_t m;
    m = MOVE_NONE;
    case ({p, c})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: m = MOVE_UP;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: m = MOVE_DOWN;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: m = MOVE_ILLEGAL;
      default:                                m = MOVE_NONE;
    endcase
    return m;
  endfunction

  logic [SYNC_STAGES-1:0] qa_sync_r;
  logic [SYNC_STAGES-1:0] qb_sync_r;
  logic [1:0]             prev_r;
  logic [1:0]             cur_s;
  move_t                  move_s;

  logic [WIDTH-1:0] pos_r, pos_n_s;
  logic             dir_r, dir_n_s;
  logic             step_r, step_n_s;
  logic             wrap_r, wrap_n_s;
  logic             err_r, err_n_s;

  assign cur_s  = {qa_sync_r[SYNC_STAGES-1], qb_sync_r[SYNC_STAGES-1]};
  assign move_s = decode_move(prev_r, cur_s);

  // Synchroniser chains and previous-sample register; prev tracks cur even when disabled or cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      qa_sync_r <= {SYNC_STAGES{1'b0}};
      qb_sync_r <= {SYNC_STAGES{1'b0}};
      prev_r    <= 2'b00;
    end else begin
      qa_sync_r <= {qa_sync_r[SYNC_STAGES-2:0], bus.qa};
      qb_sync_r <= {qb_sync_r[SYNC_STAGES-2:0], bus.qb};
      prev_r    <= cur_s;
    end
  end

  // Next position/direction/strobes; clear overrides a concurrent step but leaves dir alone.
  always_comb begin
    pos_n_s  = pos_r;
    dir_n_s  = dir_r;
    step_n_s = 1'b0;
    wrap_n_s = 1'b0;
    if (bus.enable) begin
      case (move_s)
        MOVE_UP: begin
          step_n_s = 1'b1;
          dir_n_s  = 1'b1;
          if (pos_r == POS_MAX) begin
            pos_n_s  = POS_ZERO;
            wrap_n_s = 1'b1;
          end else begin
            pos_n_s  = pos_r + POS_ONE;
          end
        end
        MOVE_DOWN: begin
          step_n_s = 1'b1;
          dir_n_s  = 1'b0;
          if (pos_r == POS_ZERO) begin
            pos_n_s  = POS_MAX;
            wrap_n_s = 1'b1;
          end else begin
            pos_n_s  = pos_r - POS_ONE;
          end
        end
        default: begin
          pos_n_s = pos_r;
        end
      endcase
    end else begin
      pos_n_s = pos_r;
    end
    if (bus.clear) begin
      pos_n_s  = POS_ZERO;
      dir_n_s  = dir_r;
      step_n_s = 1'b0;
      wrap_n_s = 1'b0;
    end else begin
      pos_n_s  = pos_n_s;
    end
  end

  // Sticky error: a set in the same cycle as err_clr wins.
  always_comb begin
    err_n_s = err_r;
    if (bus.enable && (move_s == MOVE_ILLEGAL)) begin
      err_n_s = 1'b1;
    end else if (bus.err_clr) begin
      err_n_s = 1'b0;
    end else begin
      err_n_s = err_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r  <= POS_ZERO;
      dir_r  <= 1'b0;
      step_r <= 1'b0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      pos_r  <= pos_n_s;
      dir_r  <= dir_n_s;
      step_r <= step_n_s;
      wrap_r <= wrap_n_s;
      err_r  <= err_n_s;
    end
  end

  assign bus.position = pos_r;
  assign bus.dir      = dir_r;
  assign bus.step     = step_r;
  assign bus.wrap     = wrap_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_quad_decoder_modn.sv
// Directed bench for quad_decoder_modn (N=10): counting, wrap, error, enable, clear and reset behaviour.
`timescale 1ns/1ps
module tb_quad_decoder_modn;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [1:0] ab;
  logic [3:0] exp_pos;

  quad_decoder_modn_if #(.WIDTH(4)) bus ();

  quad_decoder_modn #(.N(10), .WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] up_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] down_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new {a,b}, check outputs 2 edges after capture, then check the strobes dropped.
  task automatic trans(input string tag, input logic [1:0] nab, input logic [3:0] epos,
                       input logic estep, input logic ewrap, input logic edir, input logic eerr);
    ab = nab;
    bus.qa = nab[1];
    bus.qb = nab[0];
    tick();
    tick();
    check_val({tag, " step early"}, {31'd0, bus.step}, 32'd0);
    tick();
    check_val({tag, " position"}, {28'd0, bus.position}, {28'd0, epos});
    check_val({tag, " step"}, {31'd0, bus.step}, {31'd0, estep});
    check_val({tag, " wrap"}, {31'd0, bus.wrap}, {31'd0, ewrap});
    check_val({tag, " dir"}, {31'd0, bus.dir}, {31'd0, edir});
    check_val({tag, " err"}, {31'd0, bus.err}, {31'd0, eerr});
    tick();
    check_val({tag, " step drop"}, {31'd0, bus.step}, 32'd0);
    check_val({tag, " wrap drop"}, {31'd0, bus.wrap}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ab           = 2'b00;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.clear    = 1'b0;
    bus.err_clr  = 1'b0;
    bus.qa       = 1'b0;
    bus.qb       = 1'b0;
    tick();
    tick();
    reset      = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_val("reset position", {28'd0, bus.position}, 32'd0);
    check_val("reset dir", {31'd0, bus.dir}, 32'd0);
    check_val("reset step", {31'd0, bus.step}, 32'd0);
    check_val("reset wrap", {31'd0, bus.wrap}, 32'd0);
    check_val("reset err", {31'd0, bus.err}, 32'd0);

    // Four up steps 0 -> 4, then four down back to 0.
    trans("up1", 2'b10, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("up2", 2'b11, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("up3", 2'b01, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("up4", 2'b00, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("dn1", 2'b01, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    trans("dn2", 2'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    trans("dn3", 2'b10, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    trans("dn4", 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Down wrap 0 -> 9, then ten ups with a single wrap at 9 -> 0.
    trans("dn wrap", 2'b01, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_pos = 4'd9;
    for (int i = 0; i < 10; i++) begin
      if (exp_pos == 4'd9) begin
        trans("up loop", up_of(ab), 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_pos = 4'd0;
      end else begin
        trans("up loop", up_of(ab), exp_pos + 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_pos = exp_pos + 4'd1;
      end
    end

    // Illegal double-bit jump: state 10 -> 01.
    trans("illegal", 2'b01, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_val("err_clr", {31'd0, bus.err}, 32'd0);

    // Illegal jump 01 -> 10 with err_clr held through the decode edge.
    ab = 2'b10;
    bus.err_clr = 1'b1;
    bus.qa = 1'b1;
    bus.qb = 1'b0;
    tick();
    tick();
    tick();
    bus.err_clr = 1'b0;
    check_val("set beats clr", {31'd0, bus.err}, 32'd1);
    check_val("set beats clr pos", {28'd0, bus.position}, 32'd9);
    tick();
    check_val("err sticky", {31'd0, bus.err}, 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_val("err_clr 2", {31'd0, bus.err}, 32'd0);

    // Disabled: three ups are ignored, no catch-up once re-enabled.
    bus.enable = 1'b0;
    trans("dis1", 2'b11, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    trans("dis2", 2'b01, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    trans("dis3", 2'b00, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.enable = 1'b1;
    tick();
    tick();
    check_val("reenable pos", {28'd0, bus.position}, 32'd9);
    check_val("reenable step", {31'd0, bus.step}, 32'd0);
    trans("after en", 2'b10, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reach position 5 with dir = 0, then clear coincident with an up step.
    trans("to1", 2'b11, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("to2", 2'b01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("to3", 2'b00, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("to4", 2'b10, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("to5", 2'b11, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("to6", 2'b01, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("back5", 2'b11, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    ab = 2'b01;
    bus.qa = 1'b0;
    bus.qb = 1'b1;
    tick();
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_val("clear pos", {28'd0, bus.position}, 32'd0);
    check_val("clear step", {31'd0, bus.step}, 32'd0);
    check_val("clear wrap", {31'd0, bus.wrap}, 32'd0);
    check_val("clear dir", {31'd0, bus.dir}, 32'd0);
    tick();
    trans("post clear", 2'b00, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Climb to 7, raise err, then reset while the phases toggle.
    exp_pos = 4'd1;
    for (int i = 0; i < 6; i++) begin
      trans("to7", up_of(ab), exp_pos + 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      exp_pos = exp_pos + 4'd1;
    end
    trans("illegal7", 2'b00, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    ab = 2'b10;
    bus.qa = 1'b1;
    bus.qb = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    bus.qb = 1'b1;
    tick();
    check_val("midreset pos", {28'd0, bus.position}, 32'd0);
    check_val("midreset dir", {31'd0, bus.dir}, 32'd0);
    check_val("midreset step", {31'd0, bus.step}, 32'd0);
    check_val("midreset wrap", {31'd0, bus.wrap}, 32'd0);
    check_val("midreset err", {31'd0, bus.err}, 32'd0);
    bus.qa = 1'b0;
    tick();
    bus.qb = 1'b0;
    ab = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check_val("resume idle pos", {28'd0, bus.position}, 32'd0);
    check_val("resume idle err", {31'd0, bus.err}, 32'd0);
    trans("resume up", up_of(ab), 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    trans("resume dn", down_of(ab), 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
